// File: rtl/poly_voice_engine_if.sv
// poly_voice_engine_if: note-event handshake and sample stream between keypad decoder, engine and DAC path
interface poly_voice_engine_if #(
    parameter int NUM_VOICES = 4,
    parameter int OUT_WIDTH  = 24
);
    logic                        sample_en_i;
    logic [1:0]                  mode_i;
    logic                        note_valid_i;
    logic                        note_ready_o;
    logic                        note_on_i;
    logic [3:0]                  note_key_i;
    logic                        note_drop_o;
    logic                        overrun_o;
    logic signed [OUT_WIDTH-1:0] sample_o;
    logic                        sample_valid_o;
    logic [NUM_VOICES-1:0]       active_voices_o;
    modport master (
        output sample_en_i, mode_i, note_valid_i, note_on_i, note_key_i,
        input  note_ready_o, note_drop_o, overrun_o, sample_o, sample_valid_o, active_voices_o
    );
    modport slave (
        input  sample_en_i, mode_i, note_valid_i, note_on_i, note_key_i,
        output note_ready_o, note_drop_o, overrun_o, sample_o, sample_valid_o, active_voices_o
    );
endinterface

// File: rtl/poly_voice_engine.sv
// poly_voice_engine: time-multiplexed polyphonic oscillator with voice allocation, linear envelopes and mixing
module poly_voice_engine #(
    parameter int NUM_VOICES   = 4,
    parameter int ACC_WIDTH    = 32,
    parameter int OUT_WIDTH    = 24,
    parameter int ENV_WIDTH    = 16,
    parameter int ATTACK_STEP  = 1024,
    parameter int RELEASE_STEP = 1024,
    parameter int SAMPLE_RATE  = 48000
) (
    input logic clk_i,
    input logic reset_ni,
    poly_voice_engine_if.slave bus
);
    localparam int SH = $clog2(NUM_VOICES);
    localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    localparam int AW = OUT_WIDTH + SH;
    localparam int PW = OUT_WIDTH + ENV_WIDTH + 1;
    localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;
    localparam logic signed [OUT_WIDTH-1:0] PEAK = {1'b0, {(OUT_WIDTH-1){1'b1}}};

    function automatic logic [ACC_WIDTH-1:0] inc_of(input longint f);
        return ACC_WIDTH'((f << ACC_WIDTH) / SAMPLE_RATE);
    endfunction

    localparam logic [ACC_WIDTH-1:0] INC [16] = '{
        inc_of(261), inc_of(294), inc_of(330), inc_of(349), inc_of(392), inc_of(440), inc_of(494), inc_of(523),
        inc_of(587), inc_of(659), inc_of(698), inc_of(784), inc_of(880), inc_of(988), inc_of(1046), inc_of(1174)
    };

    typedef enum logic [1:0] {IDLE, MIX, OUT} state_t;
    typedef enum logic [1:0] {V_OFF, V_ATTACK, V_SUSTAIN, V_RELEASE} vstate_t;

    state_t                      r_state, w_state_n;
    logic [VW-1:0]               r_cnt;
    logic [1:0]                  r_mode;
    logic signed [AW-1:0]        r_acc;
    logic signed [OUT_WIDTH-1:0] r_sample;
    logic                        r_valid, r_drop, r_overrun;
    vstate_t                     r_vst   [NUM_VOICES];
    logic [ENV_WIDTH-1:0]        r_env   [NUM_VOICES];
    logic [ACC_WIDTH-1:0]        r_phase [NUM_VOICES];
    logic [3:0]                  r_key   [NUM_VOICES];

    logic                        w_accept, w_start, w_last;
    logic                        w_same_hit, w_off_hit, w_rel_hit, w_tgt_hit;
    logic [VW-1:0]               w_same_idx, w_off_idx, w_rel_idx, w_tgt;
    logic [NUM_VOICES-1:0]       w_active;
    logic [ACC_WIDTH-1:0]        w_phase_adv, w_phase_n;
    logic [ENV_WIDTH:0]          w_env_up;
    logic                        w_att_full, w_rel_empty;
    logic [ENV_WIDTH-1:0]        w_env_n;
    vstate_t                     w_vst_n;
    logic [OUT_WIDTH-1:0]        w_u, w_t, w_tf;
    logic signed [OUT_WIDTH-1:0] w_wave, w_vout;

    assign w_accept = bus.note_valid_i && r_state == IDLE;
    assign w_start  = bus.sample_en_i && r_state == IDLE;
    assign w_last   = r_cnt == VW'(NUM_VOICES - 1);

    always_comb begin
        w_state_n = r_state == IDLE ? (bus.sample_en_i ? MIX : IDLE) :
                    r_state == MIX  ? (w_last ? OUT : MIX) : IDLE;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_mode    <= '0;
            r_acc     <= '0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_drop    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= r_state == MIX ? r_cnt + VW'(1) : '0;
            r_mode    <= w_start ? bus.mode_i : r_mode;
            r_acc     <= w_start ? '0 : r_state == MIX ? r_acc + AW'(w_vout) : r_acc;
            r_sample  <= r_state == OUT ? OUT_WIDTH'(r_acc >>> SH) : r_sample;
            r_valid   <= r_state == OUT;
            r_drop    <= w_accept && bus.note_on_i && !w_tgt_hit;
            r_overrun <= bus.sample_en_i && r_state != IDLE;
        end
    end

    // Lowest-index search for each note-on allocation class, resolved by priority below
    always_comb begin
        w_same_hit = 1'b0;
        w_off_hit  = 1'b0;
        w_rel_hit  = 1'b0;
        w_same_idx = '0;
        w_off_idx  = '0;
        w_rel_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (r_vst[i] != V_OFF && r_key[i] == bus.note_key_i) begin
                w_same_hit = 1'b1;
                w_same_idx = VW'(i);
            end
            if (r_vst[i] == V_OFF) begin
                w_off_hit = 1'b1;
                w_off_idx = VW'(i);
            end
            if (r_vst[i] == V_RELEASE) begin
                w_rel_hit = 1'b1;
                w_rel_idx = VW'(i);
            end
        end
        w_tgt_hit = w_same_hit || w_off_hit || w_rel_hit;
        w_tgt     = w_same_hit ? w_same_idx : w_off_hit ? w_off_idx : w_rel_idx;
    end

    always_comb begin
        w_active = '0;
        for (int i = 0; i < NUM_VOICES; i++) w_active[i] = r_vst[i] != V_OFF;
    end

    assign w_phase_adv = r_phase[r_cnt] + INC[r_key[r_cnt]];
    assign w_env_up    = {1'b0, r_env[r_cnt]} + (ENV_WIDTH+1)'(ATTACK_STEP);
    assign w_att_full  = w_env_up >= {1'b0, ENV_MAX};
    assign w_rel_empty = {1'b0, r_env[r_cnt]} <= (ENV_WIDTH+1)'(RELEASE_STEP);

    always_comb begin
        w_env_n = r_env[r_cnt];
        w_vst_n = r_vst[r_cnt];
        if (r_vst[r_cnt] == V_ATTACK) begin
            w_env_n = w_att_full ? ENV_MAX : w_env_up[ENV_WIDTH-1:0];
            w_vst_n = w_att_full ? V_SUSTAIN : V_ATTACK;
        end else if (r_vst[r_cnt] == V_RELEASE) begin
            w_env_n = w_rel_empty ? '0 : r_env[r_cnt] - ENV_WIDTH'(RELEASE_STEP);
            w_vst_n = w_rel_empty ? V_OFF : V_RELEASE;
        end
    end

    // OFF voices always park at phase 0, so a finished release and an idle voice look alike
    assign w_phase_n = w_vst_n == V_OFF ? '0 : w_phase_adv;

    assign w_u    = w_phase_adv[ACC_WIDTH-1 -: OUT_WIDTH];
    assign w_t    = w_phase_adv[ACC_WIDTH-2 -: OUT_WIDTH];
    assign w_tf   = w_t[OUT_WIDTH-1] ? ~w_t : w_t;
    assign w_wave = r_mode == 2'd0 ? {~w_u[OUT_WIDTH-1], w_u[OUT_WIDTH-2:0]} :
                    r_mode == 2'd1 ? (w_phase_adv[ACC_WIDTH-1] ? -PEAK : PEAK) :
                    r_mode == 2'd2 ? {~w_tf[OUT_WIDTH-1], w_tf[OUT_WIDTH-2:0]} : '0;
    assign w_vout = OUT_WIDTH'((PW'(w_wave) * PW'($signed({1'b0, w_env_n}))) >>> ENV_WIDTH);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_vst[i]   <= V_OFF;
                r_env[i]   <= '0;
                r_phase[i] <= '0;
                r_key[i]   <= '0;
            end
        end else if (r_state == MIX) begin
            r_vst[r_cnt]   <= w_vst_n;
            r_env[r_cnt]   <= w_env_n;
            r_phase[r_cnt] <= w_phase_n;
        end else if (w_accept && bus.note_on_i) begin
            if (w_tgt_hit) begin
                r_vst[w_tgt] <= V_ATTACK;
                r_key[w_tgt] <= bus.note_key_i;
                if (!w_same_hit) begin
                    r_env[w_tgt]   <= '0;
                    r_phase[w_tgt] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int i = 0; i < NUM_VOICES; i++)
                if (r_key[i] == bus.note_key_i && (r_vst[i] == V_ATTACK || r_vst[i] == V_SUSTAIN))
                    r_vst[i] <= V_RELEASE;
        end
    end

    assign bus.note_ready_o    = r_state == IDLE;
    assign bus.note_drop_o     = r_drop;
    assign bus.overrun_o       = r_overrun;
    assign bus.sample_o        = r_sample;
    assign bus.sample_valid_o  = r_valid;
    assign bus.active_voices_o = w_active;
endmodule
